spi_sram_wishbone_bridge: RTL and testbench

- Wishbone B4 classic slave with an 8-bit data bus. Serves as the memory responder for the Levenshtein controller's Wishbone master (dictionary reads, bitvector reads, result writes).
- Each single-byte Wishbone access becomes one SPI-mode-0 transaction to an external serial SRAM (23LC1024-style: READ 0x03, WRITE 0x02, 24-bit address).
- SCK runs at clk_i/2.

---
 rtl/spi_sram_wishbone_bridge.sv | 151 +++++++++++++++
 tb/tb_spi_sram_wishbone_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_wishbone_bridge.sv
// Wishbone B4 classic 8-bit slave that turns each byte access into one
// SPI mode-0 READ/WRITE frame to a 23LC1024-style serial SRAM.
module spi_sram_wishbone_bridge #(
  parameter int ADDR_WIDTH     = 24,
  parameter int CS_IDLE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_n_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam int GW = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ACK,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [39:0]   sr_q, sr_d;
  logic [5:0]    bit_q, bit_d;
  logic          phase_q, phase_d;
  logic [7:0]    rx_q, rx_d;
  logic          we_q, we_d;
  logic          abort_q, abort_d;
  logic          ack_q, ack_d;
  logic [7:0]    dat_q, dat_d;
  logic [GW-1:0] gap_q, gap_d;

  logic        req;
  logic        gap_done;
  logic        accept;
  logic [23:0] adr24;
  logic [7:0]  rx_next;

  assign req      = wbs_cyc_i && wbs_stb_i;
  assign gap_done = (gap_q == GW'(CS_IDLE_CYCLES - 1));
  assign rx_next  = {rx_q[6:0], spi_miso_i};

  // The last GAP cycle doubles as an idle cycle so back-to-back
  // requests keep the 82-cycle period.
  assign accept = req && !ack_q &&
                  ((state_q == IDLE) ||
                   ((state_q == GAP) && gap_done));

  always_comb begin
    adr24 = '0;
    adr24[ADDR_WIDTH-1:0] = wbs_adr_i;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    rx_d    = rx_q;
    we_d    = we_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    gap_d   = gap_q;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        if (!req) abort_d = 1'b1;
        phase_d = !phase_q;
        if (phase_q) begin
          sr_d  = {sr_q[38:0], 1'b0};
          bit_d = bit_q + 6'd1;
          if (bit_q >= 6'd32) rx_d = rx_next;
          if (bit_q == 6'd39) begin
            state_d = ACK;
            ack_d   = req && !abort_q;
            if (!we_q) dat_d = rx_next;
          end
        end
      end
      ACK: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
        else          gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHIFT;
      sr_d    = {wbs_we_i ? 8'h02 : 8'h03, adr24,
                 wbs_we_i ? wbs_dat_i : 8'h00};
      bit_d   = '0;
      phase_d = 1'b0;
      we_d    = wbs_we_i;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      rx_q    <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      rx_q    <= rx_d;
      we_q    <= we_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      gap_q   <= gap_d;
    end
  end

  assign spi_cs_n_o = (state_q != SHIFT);
  assign spi_sck_o  = (state_q == SHIFT) && phase_q;
  assign spi_mosi_o = (state_q == SHIFT) && sr_q[39];
  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign wbs_err_o  = 1'b0;
  assign wbs_rty_o  = 1'b0;

endmodule

// File: tb/tb_spi_sram_wishbone_bridge.sv
// Bench for spi_sram_wishbone_bridge: serial SRAM device model, cycle-level
// reference of the Wishbone/SPI behaviour, randomized and directed traffic.
module tb_spi_sram_wishbone_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic [23:0] wbs_adr_i = '0;
  logic        wbs_we_i = 1'b0;
  logic [7:0]  wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;
  logic [7:0]  wbs_dat_o;
  logic        spi_sck_o;
  logic        spi_cs_n_o;
  logic        spi_mosi_o;
  logic        spi_miso_i = 1'b0;

  always #5 clk_i = ~clk_i;

  spi_sram_wishbone_bridge dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_err_o  (wbs_err_o),
    .wbs_rty_o  (wbs_rty_o),
    .wbs_dat_o  (wbs_dat_o),
    .spi_sck_o  (spi_sck_o),
    .spi_cs_n_o (spi_cs_n_o),
    .spi_mosi_o (spi_mosi_o),
    .spi_miso_i (spi_miso_i)
  );

  // Memories: ref_mem is the expectation, dev_mem lives in the SRAM model.
  logic [7:0] ref_mem [int];
  logic [7:0] dev_mem [int];

  function automatic logic [7:0] dflt(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] dev_rd(input int a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction

  // Serial SRAM device model.
  int          nbits = 0;
  int          frames = 0;
  logic [39:0] dsh = '0;
  logic [39:0] last_frame = '0;
  logic [7:0]  rdb = '0;
  logic        rdcmd = 1'b0;

  always @(posedge spi_sck_o or posedge spi_cs_n_o) begin
    if (spi_cs_n_o) begin
      nbits = 0;
    end else begin
      dsh = {dsh[38:0], spi_mosi_o};
      nbits++;
      if (nbits == 32) begin
        rdcmd = (dsh[31:24] == 8'h03);
        rdb   = dev_rd(int'(dsh[23:0]));
      end
      if (nbits == 40) begin
        last_frame = dsh;
        frames++;
        if (dsh[39:32] == 8'h02) dev_mem[int'(dsh[31:8])] = dsh[7:0];
      end
    end
  end

  always @(negedge spi_sck_o) begin
    if (!spi_cs_n_o && rdcmd && nbits >= 32 && nbits < 40)
      spi_miso_i = rdb[39 - nbits];
    else
      spi_miso_i = 1'b0;
  end

  // Reference: t is the cycle index Tn of the current transaction
  // (-1 when idle), 81 = ack cycle, 82 = chip-select gap.
  int          t = -1;
  logic [39:0] mframe = '0;
  logic        mwe = 1'b0;
  logic        mab = 1'b0;
  logic [7:0]  mdat = '0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      t    = -1;
      mdat = 8'h00;
      mab  = 1'b0;
    end else if (t == -1 || t == 82) begin
      if (wbs_cyc_i && wbs_stb_i) begin
        mwe    = wbs_we_i;
        mframe = {mwe ? 8'h02 : 8'h03, wbs_adr_i,
                  mwe ? wbs_dat_i : 8'h00};
        mab    = 1'b0;
        t      = 1;
      end else begin
        t = -1;
      end
    end else begin
      if (t <= 80 && !(wbs_cyc_i && wbs_stb_i)) mab = 1'b1;
      if (t == 80) begin
        if (mwe) ref_mem[int'(mframe[31:8])] = mframe[7:0];
        else     mdat = ref_rd(int'(mframe[31:8]));
      end
      t++;
    end
  end

  typedef struct {
    string       nm;
    logic [63:0] a;
    logic [63:0] e;
  } lit_t;

  lit_t lits[$];

  function automatic void lit(input string nm, input logic [63:0] a,
                              input logic [63:0] e);
    lits.push_back('{nm, a, e});
  endfunction

  // Single compare process: literal checks plus per-cycle model compare.
  int tests = 0;
  int fails = 0;
  int nprint = 0;

  always @(negedge clk_i) begin
    lit_t l;
    logic        ins;
    logic [13:0] got;
    logic [13:0] exp;
    while (lits.size() > 0) begin
      l = lits.pop_front();
      tests++;
      if (l.a !== l.e) begin
        fails++;
        $display("FAIL %s: got %0h, expected %0h", l.nm, l.a, l.e);
      end
    end
    if (rst_i) begin
      ins = (t >= 1 && t <= 80);
      exp = {!ins, ins && (t % 2 == 0),
             ins ? mframe[39 - (t - 1) / 2] : 1'b0,
             (t == 81) && !mab, 1'b0, 1'b0, mdat};
      got = {spi_cs_n_o, spi_sck_o, spi_mosi_o, wbs_ack_o,
             wbs_err_o, wbs_rty_o, wbs_dat_o};
      tests++;
      if (got !== exp) begin
        fails++;
        if (nprint < 40) begin
          nprint++;
          $display("FAIL cycle t=%0d {cs,sck,mosi,ack,err,rty,dat}: got %b, expected %b",
                   t, got, exp);
        end
      end
    end
  end

  task automatic set_req(input logic we, input logic [23:0] adr,
                         input logic [7:0] d);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = d;
  endtask

  task automatic idle_bus();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'($urandom_range(0, 1));
    wbs_adr_i = 24'($urandom);
    wbs_dat_i = 8'($urandom);
  endtask

  // Called just after driving a request; returns at the negedge of the ack
  // cycle with n = clock edges from the request to the ack.
  task automatic wait_ack(input bit scramble, output int n);
    n = 0;
    forever begin
      @(negedge clk_i);
      if (wbs_ack_o) break;
      if (n >= 200) begin
        lit("ack_timeout", 64'(n), 64'(81));
        break;
      end
      @(posedge clk_i);
      n++;
      #1;
      if (scramble && $urandom_range(0, 3) == 0) begin
        wbs_we_i  = 1'($urandom_range(0, 1));
        wbs_adr_i = 24'($urandom);
        wbs_dat_i = 8'($urandom);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int          n;
    int          f0;
    logic        we_r;
    logic [23:0] adr_r;
    logic [7:0]  dat_r;
    int          gap;

    dev_mem[32'h10] = 8'h3C;
    ref_mem[32'h10] = 8'h3C;
    dev_mem[0]      = 8'h77;
    ref_mem[0]      = 8'h77;

    #1 rst_i = 1'b0;
    #1;
    lit("rst_cs_n", 64'(spi_cs_n_o), 64'(1));
    lit("rst_sck_mosi_ack", 64'({spi_sck_o, spi_mosi_o, wbs_ack_o}), 64'(0));
    lit("rst_dat", 64'(wbs_dat_o), 64'(0));
    step(3);
    rst_i = 1'b1;
    step(2);

    set_req(1'b1, 24'h012345, 8'hA5);
    wait_ack(1'b0, n);
    lit("wr_latency", 64'(n), 64'(81));
    lit("wr_frame", 64'(last_frame), 64'h02_012345_A5);
    lit("wr_mem", 64'(dev_rd(32'h012345)), 64'hA5);
    step(1);
    idle_bus();
    step(3);

    set_req(1'b0, 24'h000010, 8'hFF);
    wait_ack(1'b0, n);
    lit("rd_dat", 64'(wbs_dat_o), 64'h3C);
    lit("rd_frame", 64'(last_frame), 64'h03_000010_00);
    step(1);
    set_req(1'b1, 24'h000011, 8'h5E);
    wait_ack(1'b0, n);
    lit("b2b_latency", 64'(n), 64'(81));
    lit("b2b_frame", 64'(last_frame), 64'h02_000011_5E);
    lit("rd_hold", 64'(wbs_dat_o), 64'h3C);
    step(1);
    idle_bus();
    step(2);

    f0 = frames;
    set_req(1'b0, 24'h000012, 8'h00);
    step(20);
    idle_bus();
    step(100);
    lit("abort_frame_done", 64'(frames - f0), 64'(1));
    set_req(1'b0, 24'h000011, 8'h00);
    wait_ack(1'b0, n);
    lit("post_abort_rd", 64'(wbs_dat_o), 64'h5E);
    step(1);
    idle_bus();
    step(2);

    for (int i = 0; i < 40; i++) begin
      we_r  = 1'($urandom_range(0, 1));
      adr_r = (i % 6 == 5) ? (24'($urandom) | 24'h000100)
                           : 24'h400000 + 24'($urandom_range(1, 6));
      dat_r = 8'($urandom);
      set_req(we_r, adr_r, dat_r);
      if ($urandom_range(0, 7) == 0) begin
        step($urandom_range(1, 80));
        idle_bus();
        step(100);
      end else begin
        wait_ack(1'b1, n);
        step(1);
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          idle_bus();
          step(gap);
        end
      end
    end
    idle_bus();
    step(3);

    set_req(1'b1, 24'h7FFF20, 8'h99);
    step(40);
    #2;
    rst_i = 1'b0;
    idle_bus();
    #1;
    lit("midrst_cs_n", 64'(spi_cs_n_o), 64'(1));
    lit("midrst_sck", 64'(spi_sck_o), 64'(0));
    lit("midrst_mosi", 64'(spi_mosi_o), 64'(0));
    lit("midrst_dat", 64'(wbs_dat_o), 64'(0));
    step(3);
    #2 rst_i = 1'b1;
    step(2);
    lit("midrst_no_write", 64'(dev_rd(32'h7FFF20)), 64'(dflt(32'h7FFF20)));

    set_req(1'b0, 24'h000000, 8'h00);
    wait_ack(1'b0, n);
    lit("postrst_latency", 64'(n), 64'(81));
    lit("postrst_rd", 64'(wbs_dat_o), 64'h77);
    step(1);
    idle_bus();
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
